// File: rtl/layers_frame_arbiter_if.sv
// layers_frame_arbiter_if: per-layer AXIS frame inputs plus the merged AXIS output stream.
// master drives the layer sources and output backpressure; slave is the arbiter.
interface layers_frame_arbiter_if #(
    parameter int LAYER_COUNT = 3
);
    logic [LAYER_COUNT*8-1:0] s_axis_tdata;
    logic [LAYER_COUNT-1:0]   s_axis_tvalid;
    logic [LAYER_COUNT-1:0]   s_axis_tlast;
    logic [LAYER_COUNT-1:0]   s_axis_tready;
    logic [7:0]               m_axis_tdata;
    logic [7:0]               m_axis_tdest;
    logic                     m_axis_tvalid;
    logic                     m_axis_tlast;
    logic                     m_axis_tready;
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tdest, m_axis_tvalid, m_axis_tlast
    );
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tdest, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/layers_frame_arbiter.sv
// layers_frame_arbiter: round-robin, frame-atomic merge of per-layer AXIS streams onto one output.
// Define LAYERS_ARB_WATCHDOG_EN to release grants held by stalled frames after config_idle_timeout cycles.
module layers_frame_arbiter #(
    parameter int LAYER_COUNT = 3
) (
    input  logic                   clk_core,
    input  logic                   clk_core_rst,
    layers_frame_arbiter_if.slave  axis,
    input  logic [LAYER_COUNT-1:0] config_layers_enable,
    input  logic [15:0]            config_idle_timeout,
    output logic [LAYER_COUNT-1:0] status_grant,
    output logic                   status_busy,
    output logic                   stat_frame_done,
    output logic                   stat_timeout
);
    localparam int IW = LAYER_COUNT > 1 ? $clog2(LAYER_COUNT) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    logic [0:0]             state;
    logic [IW-1:0]          grant;
    logic [IW-1:0]          last_grant;
    logic [IW-1:0]          pick;
    logic [LAYER_COUNT-1:0] req;
    logic [3:0]             idx;
    logic                   found;
    logic                   xfer;
    logic                   wd_expire;
    assign status_busy = state == GRANT;
    assign req = status_busy ? '0 : axis.s_axis_tvalid & config_layers_enable;
    // search starts just after the previous owner and wraps, giving round-robin order
    always_comb begin
        pick = last_grant;
        found = 1'b0;
        idx = '0;
        for (int k = 1; k <= LAYER_COUNT; k++) begin
            idx = 4'(last_grant) + 4'(k);
            idx = idx >= 4'(LAYER_COUNT) ? idx - 4'(LAYER_COUNT) : idx;
            if (!found && req[IW'(idx)]) begin
                pick = IW'(idx);
                found = 1'b1;
            end
        end
    end
    assign axis.m_axis_tvalid = status_busy & axis.s_axis_tvalid[grant];
    assign axis.m_axis_tlast = status_busy & axis.s_axis_tlast[grant];
    assign axis.m_axis_tdata = status_busy ? axis.s_axis_tdata[grant*8 +: 8] : 8'h00;
    assign axis.m_axis_tdest = status_busy ? 8'(grant) + 8'd1 : 8'h00;
    assign axis.s_axis_tready = status_busy && axis.m_axis_tready ? LAYER_COUNT'(1) << grant : '0;
    assign status_grant = status_busy ? LAYER_COUNT'(1) << grant : '0;
    assign xfer = axis.m_axis_tvalid & axis.m_axis_tready;
    always_ff @(posedge clk_core or posedge clk_core_rst) begin
        if (clk_core_rst) begin
            state <= IDLE;
            grant <= '0;
            last_grant <= IW'(LAYER_COUNT - 1);
            stat_frame_done <= 1'b0;
        end else begin
            stat_frame_done <= 1'b0;
            if (state == IDLE) begin
                if (found) begin
                    grant <= pick;
                    state <= GRANT;
                end
            end else if (xfer && axis.m_axis_tlast) begin
                last_grant <= grant;
                state <= IDLE;
                stat_frame_done <= 1'b1;
            end else if (wd_expire) begin
                last_grant <= grant;
                state <= IDLE;
            end
        end
    end
`ifdef LAYERS_ARB_WATCHDOG_EN
    logic [15:0] wd_cnt;
    // expires on the cycle that would make the stall count reach the limit
    assign wd_expire = status_busy && !xfer && config_idle_timeout != 16'd0 &&
                       17'(wd_cnt) + 17'd1 >= 17'(config_idle_timeout);
    always_ff @(posedge clk_core or posedge clk_core_rst) begin
        if (clk_core_rst) begin
            wd_cnt <= '0;
            stat_timeout <= 1'b0;
        end else begin
            stat_timeout <= wd_expire;
            wd_cnt <= !status_busy || xfer || wd_expire ? '0 :
                      wd_cnt == 16'hffff ? wd_cnt : wd_cnt + 16'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^config_idle_timeout;
    assign wd_expire = 1'b0;
    assign stat_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_layers_frame_arbiter.sv
// tb_layers_frame_arbiter: directed and random frame traffic checked cycle by cycle
// against a frame-level round-robin reference model.
module tb_layers_frame_arbiter;
    localparam int N = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] en = '1;
    logic [15:0] tmo = '0;
    logic [N-1:0] status_grant;
    logic status_busy, stat_frame_done, stat_timeout;
    layers_frame_arbiter_if #(.LAYER_COUNT(N)) axis ();
    layers_frame_arbiter #(.LAYER_COUNT(N)) dut (
        .clk_core(clk), .clk_core_rst(rst), .axis(axis),
        .config_layers_enable(en), .config_idle_timeout(tmo),
        .status_grant(status_grant), .status_busy(status_busy),
        .stat_frame_done(stat_frame_done), .stat_timeout(stat_timeout)
    );
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    int m_busy = 0, m_own = 0, m_last = N - 1, m_wd = 0;
    bit exp_done = 0, exp_tmo = 0;
    int rem[N], pos[N], stall_at[N];
    logic [7:0] fb[N][8];
    int ready_pct = 100, gap_pct = 0, seen1 = 0, tmo_seen = 0, n = 0;
    int done_order[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int i, input int len);
        for (int p = 0; p < len; p++) fb[i][p] = 8'($urandom);
        rem[i] = len;
        pos[i] = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            axis.s_axis_tvalid[i] = rem[i] > 0 && pos[i] != stall_at[i] && $urandom_range(99) >= gap_pct;
            axis.s_axis_tdata[i*8 +: 8] = rem[i] > 0 ? fb[i][pos[i]] : 8'($urandom);
            axis.s_axis_tlast[i] = rem[i] == 1;
        end
        axis.m_axis_tready = $urandom_range(99) < ready_pct;
    endtask

    task automatic chk_zero();
        chk("rst_grant", 32'(status_grant), 0);
        chk("rst_busy", 32'(status_busy), 0);
        chk("rst_tvalid", 32'(axis.m_axis_tvalid), 0);
        chk("rst_tlast", 32'(axis.m_axis_tlast), 0);
        chk("rst_tdata", 32'(axis.m_axis_tdata), 0);
        chk("rst_tdest", 32'(axis.m_axis_tdest), 0);
        chk("rst_tready", 32'(axis.s_axis_tready), 0);
        chk("rst_done", 32'(stat_frame_done), 0);
        chk("rst_timeout", 32'(stat_timeout), 0);
    endtask

    // one cycle: drive after the edge, compare at the falling edge, advance model and sources
    task automatic step();
        logic [N-1:0] v, eg;
        logic rdy, x;
        int o, req;
        drive();
        @(negedge clk);
        v = axis.s_axis_tvalid;
        rdy = axis.m_axis_tready;
        o = m_own;
        eg = m_busy != 0 ? N'(1) << o : '0;
        x = m_busy != 0 && v[o] && rdy;
        chk("frame_done", 32'(stat_frame_done), 32'(exp_done));
        chk("timeout", 32'(stat_timeout), 32'(exp_tmo));
        chk("grant", 32'(status_grant), 32'(eg));
        chk("busy", 32'(status_busy), 32'(m_busy));
        chk("tdest", 32'(axis.m_axis_tdest), m_busy != 0 ? 32'(o + 1) : 0);
        chk("tvalid", 32'(axis.m_axis_tvalid), 32'(m_busy != 0 && v[o]));
        chk("tready", 32'(axis.s_axis_tready), rdy ? 32'(eg) : 0);
        if (m_busy != 0 && v[o]) begin
            chk("tdata", 32'(axis.m_axis_tdata), 32'(fb[o][pos[o]]));
            chk("tlast", 32'(axis.m_axis_tlast), 32'(rem[o] == 1));
        end
        if (axis.s_axis_tready[1] || status_grant[1]) seen1++;
        if (stat_timeout) tmo_seen++;
        exp_done = 0;
        exp_tmo = 0;
        if (m_busy == 0) begin
            req = int'(v & en);
            for (int k = 1; k <= N && m_busy == 0; k++)
                if (req[(m_last + k) % N]) begin
                    m_own = (m_last + k) % N;
                    m_busy = 1;
                    m_wd = 0;
                end
        end else if (x && rem[o] == 1) begin
            m_last = o;
            m_busy = 0;
            exp_done = 1;
            done_order.push_back(o);
        end else if (x) begin
            m_wd = 0;
        end else begin
            m_wd++;
`ifdef LAYERS_ARB_WATCHDOG_EN
            if (tmo != 0 && m_wd >= int'(tmo)) begin
                m_last = o;
                m_busy = 0;
                exp_tmo = 1;
            end
`endif
        end
        @(posedge clk);
        #1;
        if (x) begin
            pos[o]++;
            rem[o]--;
        end
    endtask

    task automatic drain(input int max, output int cnt);
        bit pending;
        cnt = 0;
        pending = 1;
        while (pending && cnt < max) begin
            step();
            cnt++;
            pending = m_busy != 0;
            for (int i = 0; i < N; i++) if (rem[i] > 0) pending = 1;
        end
        if (pending) chk("drain_bound", 1, 0);
    endtask

    task automatic areset();
        #2 rst = 1'b1;
        #1 chk_zero();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            stall_at[i] = -1;
        end
        m_busy = 0;
        m_last = N - 1;
        m_wd = 0;
        exp_done = 0;
        exp_tmo = 0;
        drive();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            pos[i] = 0;
            stall_at[i] = -1;
        end
        drive();
        repeat (3) @(posedge clk);
        #1 chk_zero();
        rst = 1'b0;
        // three simultaneous 4-byte frames drain in layer order with one bubble each
        load(0, 4); load(1, 4); load(2, 4);
        drain(60, n);
        chk("a_cycles", 32'(n), 15);
        chk("a_frames", 32'(done_order.size()), 3);
        chk("a_order0", 32'(done_order[0]), 0);
        chk("a_order1", 32'(done_order[1]), 1);
        chk("a_order2", 32'(done_order[2]), 2);
        // layer 1 in progress keeps the output while layer 0 waits, under backpressure
        done_order.delete();
        load(1, 6);
        step(); step();
        load(0, 3);
        ready_pct = 50;
        drain(200, n);
        ready_pct = 100;
        chk("b_frames", 32'(done_order.size()), 2);
        chk("b_order0", 32'(done_order[0]), 1);
        chk("b_order1", 32'(done_order[1]), 0);
        // disabled layer 1 never wins even while valid
        en = 3'b101;
        load(1, 4);
        seen1 = 0;
        repeat (40) begin
            if (rem[0] == 0) load(0, 3);
            if (rem[2] == 0) load(2, 2);
            step();
        end
        chk("c_layer1_idle", 32'(seen1), 0);
        en = '1;
        drain(100, n);
        // layer 2 stalls after two bytes while layer 0 waits
        done_order.delete();
        tmo = 16'd10;
        load(2, 4);
        stall_at[2] = 2;
        step(); step(); step();
        load(0, 2);
        tmo_seen = 0;
        repeat (30) step();
`ifdef LAYERS_ARB_WATCHDOG_EN
        chk("d_timeouts", 32'(tmo_seen), 1);
        chk("d_frames", 32'(done_order.size()), 1);
        chk("d_order0", 32'(done_order[0]), 0);
        stall_at[2] = -1;
        drain(100, n);
`else
        chk("d_busy_held", 32'(status_busy), 1);
        chk("d_grant_held", 32'(status_grant), 32'b100);
        chk("d_frames", 32'(done_order.size()), 0);
        chk("d_timeouts", 32'(tmo_seen), 0);
`endif
        areset();
        // reset in the middle of a layer 1 frame, then restart from layer 0
        tmo = '0;
        load(1, 5);
        step(); step(); step();
        areset();
        load(0, 3); load(1, 3); load(2, 3);
        step();
        chk("e_first_grant", 32'(status_grant), 32'b001);
        drain(100, n);
        // random traffic, enables, gaps and backpressure
        tmo = 16'd5;
        ready_pct = 70;
        gap_pct = 20;
        repeat (600) begin
            en = N'($urandom);
            for (int i = 0; i < N; i++)
                if (rem[i] == 0 && $urandom_range(99) < 30) load(i, int'($urandom_range(8, 1)));
            step();
        end
        en = '1;
        gap_pct = 0;
        ready_pct = 100;
        drain(300, n);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end
endmodule

// File: doc/layers_frame_arbiter.md
LAYERS_FRAME_ARBITER -- requirements
Module: layers_frame_arbiter

Interface
REQ-001 SHALL have parameter LAYER_COUNT, default 3, meaning number of layer frame stream inputs (1..8).
REQ-002 SHALL have port clk_core  input  1  core clock; all logic on rising edge.
REQ-003 SHALL have port clk_core_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s_axis_tdata  input  LAYER_COUNT*8  per-layer frame byte; layer i at [i*8+7:i*8].
REQ-005 SHALL have ports s_axis_tvalid, s_axis_tlast (input) and s_axis_tready (output), each LAYER_COUNT wide, per-layer AXIS handshake.
REQ-006 SHALL have ports m_axis_tdata  output  8, m_axis_tdest  output  8 (layer ID), m_axis_tvalid  output  1, m_axis_tlast  output  1, m_axis_tready  input  1: merged output stream.
REQ-007 SHALL have port config_layers_enable  input  LAYER_COUNT  per-layer arbitration enable.
REQ-008 SHALL have port config_idle_timeout  input  16  stalled-frame watchdog limit in cycles; 0 = off.
REQ-009 SHALL have ports status_grant  output  LAYER_COUNT  (one-hot current owner) and status_busy  output  1.
REQ-010 SHALL have ports stat_frame_done and stat_timeout, each output 1, single-cycle event pulses.

Function
REQ-011 SHALL implement FSM states IDLE and GRANT; frames SHALL never interleave on the output.
REQ-012 In IDLE: all s_axis_tready=0, m_axis_tvalid=0, status_busy=0, status_grant=0.
REQ-013 In IDLE, request = s_axis_tvalid & config_layers_enable; when nonzero, SHALL pick the first requesting index after last_grant, wrapping modulo LAYER_COUNT, register it as grant, and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-014 In GRANT (grant g): m_axis_tdata/tvalid/tlast SHALL combinationally equal layer g's inputs; s_axis_tready[g]=m_axis_tready; all other tready=0; m_axis_tdest=g+1; status_busy=1; status_grant bit g=1.
REQ-015 On a transfer (m_axis_tvalid & m_axis_tready) with tlast=1: SHALL set last_grant=g, pulse stat_frame_done next cycle, return to IDLE; one idle bubble cycle between consecutive frames is required.
REQ-016 config_layers_enable SHALL be sampled only in IDLE; deasserting it for g mid-frame SHALL NOT interrupt the frame.
REQ-017 A single requester SHALL be re-granted repeatedly; with all layers continuously requesting, grants SHALL rotate 0,1,...,LAYER_COUNT-1,0.
REQ-018 s_axis_tvalid dropping inside a frame SHALL hold the grant (no re-arbitration until tlast or watchdog).

Reset
REQ-019 Asserting clk_core_rst SHALL immediately force IDLE, last_grant=LAYER_COUNT-1 (first search starts at layer 0), watchdog count=0, and every output to 0.
REQ-020 Reset asserted mid-frame SHALL abandon the frame without emitting tlast; after release, normal arbitration resumes from layer 0.

Configuration
REQ-021 Macro LAYERS_ARB_WATCHDOG_EN defined: a 16-bit saturating counter SHALL count GRANT cycles without a transfer, clear on any transfer or IDLE; when nonzero config_idle_timeout is reached, SHALL release grant (last_grant=g), return to IDLE, pulse stat_timeout, emit no tlast.
REQ-022 Macro LAYERS_ARB_WATCHDOG_EN undefined: no counter is implemented, config_idle_timeout is ignored, stat_timeout is constant 0, grant held until tlast.

Verification
REQ-023 Layers 0,1,2 each present a 4-byte frame simultaneously, m_axis_tready=1 -> output frames in order tdest 1,2,3, 12 bytes, 3 stat_frame_done pulses, one bubble between frames.
REQ-024 Layer 1 frame in progress, layer 0 requesting, m_axis_tready toggled 50% -> layer 1 frame completes intact before layer 0 granted; no data loss or duplication.
REQ-025 config_layers_enable=3'b101, layer 1 valid held high -> layer 1 never granted, s_axis_tready[1]=0 throughout.
REQ-026 Watchdog build, config_idle_timeout=10, granted layer 2 drops tvalid after 2 bytes -> stat_timeout pulses 10 cycles later, FSM IDLE, layer 0 then granted; non-watchdog build -> grant held indefinitely.
REQ-027 clk_core_rst pulsed during a layer 1 frame -> all outputs 0 asynchronously; after release with all layers requesting, layer 0 granted first.
